// File: rtl/adder_pkg.sv
// Shared constants and result payload for the ripple-carry adder.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH     = 4;
    localparam int unsigned ADDER_ERR_CNT_W = 8;

    // Carry-out plus sum, as captured by the output register
    typedef struct packed {
        logic                   c;
        logic [ADDER_WIDTH-1:0] s;
    } result_t;

endpackage : adder_pkg

// File: rtl/one_bit_fa.sv
// One-bit full-adder cell: the link repeated along the ripple chain.
module one_bit_fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic prop;

    // Propagate term, shared by the sum and carry equations
    assign prop  = a ^ b;
    assign sum   = prop ^ c_in;
    assign c_out = (a & b) | (c_in & prop);

endmodule : one_bit_fa

// File: rtl/four_bit_fa.sv
// Ripple-carry adder built from one-bit cells, with a registered result and a
// built-in checker that counts disagreements with a behavioural reference.
module four_bit_fa
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH     = ADDER_WIDTH,
    parameter int unsigned ERR_CNT_W = ADDER_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 c_in,
    output logic [WIDTH-1:0]     sum,
    output logic                 c_out,
    output logic [WIDTH-1:0]     sum_q,
    output logic                 c_out_q,
    output logic                 error_flag,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [WIDTH:0]     carry;
    logic [WIDTH:0]     ref_sum;
    result_t            res_d, res_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    assign carry[0] = c_in;

    // Explicit ripple chain; each cell's sum goes through a named per-cell net
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic s_bit;

        one_bit_fa u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (s_bit),
            .c_out (carry[i+1])
        );

        assign sum[i] = s_bit;
    end

    assign c_out = carry[WIDTH];

    // Behavioural reference computed alongside the structural chain
    assign ref_sum    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c_in);
    assign error_flag = ({c_out, sum} != ref_sum);

    // Next-state: capture the live result, count mismatching edges with saturation
    always_comb begin
        res_d.c   = c_out;
        res_d.s   = sum;
        err_cnt_d = err_cnt_q;
        if (error_flag && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            res_q     <= res_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sum_q     = res_q.s;
    assign c_out_q   = res_q.c;
    assign err_count = err_cnt_q;

endmodule : four_bit_fa

// File: tb/tb_four_bit_fa.sv
// Directed bench for four_bit_fa: vector table, exhaustive sweep, reset and
// checker-saturation sequences.
`timescale 1ns/1ps
module tb_four_bit_fa;

    logic       clk;
    logic       rst_n;
    logic [3:0] a, b;
    logic       c_in;
    logic [3:0] sum, sum_q;
    logic       c_out, c_out_q, error_flag;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c_in;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[12];

    four_bit_fa dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .c_in       (c_in),
        .sum        (sum),
        .c_out      (c_out),
        .sum_q      (sum_q),
        .c_out_q    (c_out_q),
        .error_flag (error_flag),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        int tot;

        vecs[0]  = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[1]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[2]  = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
        vecs[3]  = '{4'd7,  4'd8,  1'b1, 4'd0,  1'b1};
        vecs[4]  = '{4'd3,  4'd4,  1'b0, 4'd7,  1'b0};
        vecs[5]  = '{4'd5,  4'd10, 1'b1, 4'd0,  1'b1};
        vecs[6]  = '{4'd9,  4'd6,  1'b0, 4'd15, 1'b0};
        vecs[7]  = '{4'd12, 4'd3,  1'b1, 4'd0,  1'b1};
        vecs[8]  = '{4'd1,  4'd1,  1'b1, 4'd3,  1'b0};
        vecs[9]  = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0};
        vecs[10] = '{4'd14, 4'd1,  1'b0, 4'd15, 1'b0};
        vecs[11] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};

        // Reset state
        rst_n = 1'b0;
        a = 4'd6; b = 4'd3; c_in = 1'b0;
        #2;
        check("rst_sum_q",     sum_q,     0);
        check("rst_c_out_q",   c_out_q,   0);
        check("rst_err_count", err_count, 0);
        check("rst_comb_sum",  sum,       9);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset captures current inputs
        @(posedge clk); #1;
        check("first_edge_sum_q", sum_q, 9);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].c_in;
            #1;
            check($sformatf("vec%0d_sum", i),   sum,        vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i),  c_out,      vecs[i].exp_cout);
            check($sformatf("vec%0d_err", i),   error_flag, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_sum_q", i),   sum_q,   vecs[i].exp_sum);
            check($sformatf("vec%0d_c_out_q", i), c_out_q, vecs[i].exp_cout);
        end

        // Exhaustive sweep over {c_in,a,b}
        for (int code = 0; code < 512; code++) begin
            @(negedge clk);
            {c_in, a, b} = 9'(code);
            tot = int'(a) + int'(b) + int'(c_in);
            #1;
            check($sformatf("sweep%0d_sum", code),  sum,        tot % 16);
            check($sformatf("sweep%0d_cout", code), c_out,      tot / 16);
            check($sformatf("sweep%0d_err", code),  error_flag, 0);
            @(posedge clk); #1;
            check($sformatf("sweep%0d_sum_q", code),   sum_q,   tot % 16);
            check($sformatf("sweep%0d_c_out_q", code), c_out_q, tot / 16);
        end
        check("sweep_err_count", err_count, 0);

        // Maximum operands, then one edge of latency
        @(negedge clk);
        a = 4'd15; b = 4'd15; c_in = 1'b1;
        #1;
        check("max_sum",  sum,   15);
        check("max_cout", c_out, 1);
        @(posedge clk); #1;
        check("max_sum_q",   sum_q,   15);
        check("max_c_out_q", c_out_q, 1);

        // Fault in cell 2: checker flags it and the counter saturates
        @(negedge clk);
        a = 4'd4; b = 4'd0; c_in = 1'b0;
        force dut.g_cell[2].s_bit = 1'b0;
        #1;
        check("fault_sum",  sum,        0);
        check("fault_flag", error_flag, 1);
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk); #1;
            if (e == 1)   check("fault_cnt_1",   err_count, 1);
            if (e == 10)  check("fault_cnt_10",  err_count, 10);
            if (e == 254) check("fault_cnt_254", err_count, 254);
            if (e == 255) check("fault_cnt_255", err_count, 255);
            if (e == 256) check("fault_cnt_256", err_count, 255);
        end
        check("fault_cnt_300", err_count, 255);
        @(negedge clk);
        release dut.g_cell[2].s_bit;
        #1;
        check("release_flag", error_flag, 0);
        check("release_sum",  sum,        4);
        @(posedge clk); #1;
        check("release_cnt_hold", err_count, 255);

        // Mid-stream asynchronous reset between edges
        @(negedge clk);
        a = 4'd9; b = 4'd9; c_in = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_sum_q",   sum_q,   3);
        check("pre_rst_c_out_q", c_out_q, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum_q",   sum_q,     0);
        check("async_rst_c_out_q", c_out_q,   0);
        check("async_rst_cnt",     err_count, 0);
        check("async_rst_comb",    sum,       3);
        check("async_rst_cout",    c_out,     1);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_sum_q",   sum_q,   3);
        check("post_rst_c_out_q", c_out_q, 1);
        check("post_rst_cnt",     err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_four_bit_fa
